// File: rtl/taxi_dma_ram_rd_blk.sv
// Block read initiator for the segmented DMA RAM read port: issues per-segment
// read commands under a credit limit and re-assembles full-width words in order.
module taxi_dma_ram_rd_blk #(
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_W      = 16,
    parameter int SEGS       = 2,
    parameter int SEG_ADDR_W = 8,
    parameter int SEG_DATA_W = 64
) (
    input  logic                         clk,
    input  logic                         rst,

    output logic [SEGS*SEG_ADDR_W-1:0]   dma_ram_rd_cmd_addr,
    output logic [SEGS-1:0]              dma_ram_rd_cmd_valid,
    input  logic [SEGS-1:0]              dma_ram_rd_cmd_ready,
    input  logic [SEGS*SEG_DATA_W-1:0]   dma_ram_rd_resp_data,
    input  logic [SEGS-1:0]              dma_ram_rd_resp_valid,
    output logic [SEGS-1:0]              dma_ram_rd_resp_ready,

    input  logic [SEG_ADDR_W-1:0]        req_addr,
    input  logic [LEN_W-1:0]             req_len,
    input  logic                         req_valid,
    output logic                         req_ready,

    output logic [SEGS*SEG_DATA_W-1:0]   m_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic                         m_last,

    output logic                         busy,
    output logic                         done
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CRED_W = PTR_W + 1;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                 state, state_next;
    logic [SEG_ADDR_W-1:0]  base;
    logic [LEN_W-1:0]       len, out_cnt;
    logic [LEN_W-1:0]       issue_cnt [SEGS];
    logic [CRED_W-1:0]      credit    [SEGS];
    logic [SEG_DATA_W-1:0]  fifo_mem  [SEGS][FIFO_DEPTH];
    logic [PTR_W:0]         wr_ptr    [SEGS];
    logic [PTR_W:0]         rd_ptr    [SEGS];
    logic [SEGS-1:0]        fifo_empty, cmd_hs;
    logic                   accept, pop, last_word, done_next;

    always_comb begin
        dma_ram_rd_cmd_addr   = '0;
        dma_ram_rd_cmd_valid  = '0;
        dma_ram_rd_resp_ready = '1;
        m_data                = '0;
        fifo_empty            = '0;
        cmd_hs                = '0;
        for (int unsigned n = 0; n < SEGS; n++) begin
            fifo_empty[n] = (wr_ptr[n] == rd_ptr[n]);
            m_data[n*SEG_DATA_W +: SEG_DATA_W] = fifo_mem[n][rd_ptr[n][PTR_W-1:0]];
            // credit bounds the words in flight or buffered so responses never overflow
            dma_ram_rd_cmd_valid[n] = (state == ACTIVE) && (issue_cnt[n] < len)
                                      && (credit[n] < CRED_W'(FIFO_DEPTH));
            dma_ram_rd_cmd_addr[n*SEG_ADDR_W +: SEG_ADDR_W] = base + SEG_ADDR_W'(issue_cnt[n]);
            cmd_hs[n] = dma_ram_rd_cmd_valid[n] && dma_ram_rd_cmd_ready[n];
        end
    end

    always_comb begin
        req_ready  = (state == IDLE) && !rst;
        busy       = (state == ACTIVE);
        accept     = req_valid && req_ready;
        m_valid    = (state == ACTIVE) && (fifo_empty == '0);
        pop        = m_valid && m_ready;
        last_word  = (out_cnt == len - LEN_W'(1));
        m_last     = m_valid && last_word;
        state_next = state;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_len != '0) state_next = ACTIVE;
                    else               done_next  = 1'b1;
                end
            end
            ACTIVE: begin
                if (pop && last_word) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            done    <= 1'b0;
            base    <= '0;
            len     <= '0;
            out_cnt <= '0;
            for (int unsigned n = 0; n < SEGS; n++) begin
                issue_cnt[n] <= '0;
                credit[n]    <= '0;
                wr_ptr[n]    <= '0;
                rd_ptr[n]    <= '0;
            end
        end else begin
            state <= state_next;
            done  <= done_next;
            if (accept && req_len != '0) begin
                base    <= req_addr;
                len     <= req_len;
                out_cnt <= '0;
                for (int unsigned n = 0; n < SEGS; n++) begin
                    issue_cnt[n] <= '0;
                    credit[n]    <= '0;
                end
            end else begin
                if (pop) out_cnt <= out_cnt + LEN_W'(1);
                for (int unsigned n = 0; n < SEGS; n++) begin
                    if (cmd_hs[n]) issue_cnt[n] <= issue_cnt[n] + LEN_W'(1);
                    case ({cmd_hs[n], pop})
                        2'b10:   credit[n] <= credit[n] + CRED_W'(1);
                        2'b01:   credit[n] <= credit[n] - CRED_W'(1);
                        default: credit[n] <= credit[n];
                    endcase
                end
            end
            for (int unsigned n = 0; n < SEGS; n++) begin
                if (dma_ram_rd_resp_valid[n]) wr_ptr[n] <= wr_ptr[n] + (PTR_W+1)'(1);
                if (pop)                      rd_ptr[n] <= rd_ptr[n] + (PTR_W+1)'(1);
            end
        end
    end

    // Storage is not reset; responses seen during reset are dropped via the pointers.
    always_ff @(posedge clk) begin
        for (int unsigned n = 0; n < SEGS; n++) begin
            if (!rst && dma_ram_rd_resp_valid[n])
                fifo_mem[n][wr_ptr[n][PTR_W-1:0]] <= dma_ram_rd_resp_data[n*SEG_DATA_W +: SEG_DATA_W];
        end
    end

endmodule

// File: tb/tb_taxi_dma_ram_rd_blk.sv
// Bench for taxi_dma_ram_rd_blk: stub PIPELINE=2 RAM holding word a = {a, ~a},
// with a queue-based reference of the expected word stream.
module tb_taxi_dma_ram_rd_blk;

    localparam int SEGS  = 2;
    localparam int AW    = 8;
    localparam int DW    = 64;
    localparam int DEPTH = 8;
    localparam int LW    = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [SEGS*AW-1:0]   cmd_addr;
    logic [SEGS-1:0]      cmd_valid;
    logic [SEGS-1:0]      cmd_ready = '1;
    logic [SEGS*DW-1:0]   resp_data;
    logic [SEGS-1:0]      resp_valid;
    logic [SEGS-1:0]      resp_ready;
    logic [AW-1:0]        req_addr = '0;
    logic [LW-1:0]        req_len = '0;
    logic                 req_valid = 1'b0;
    logic                 req_ready;
    logic [SEGS*DW-1:0]   m_data;
    logic                 m_valid;
    logic                 m_ready = 1'b1;
    logic                 m_last;
    logic                 busy;
    logic                 done;

    always #5 clk = ~clk;

    taxi_dma_ram_rd_blk #(
        .FIFO_DEPTH (DEPTH),
        .LEN_W      (LW),
        .SEGS       (SEGS),
        .SEG_ADDR_W (AW),
        .SEG_DATA_W (DW)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .dma_ram_rd_cmd_addr   (cmd_addr),
        .dma_ram_rd_cmd_valid  (cmd_valid),
        .dma_ram_rd_cmd_ready  (cmd_ready),
        .dma_ram_rd_resp_data  (resp_data),
        .dma_ram_rd_resp_valid (resp_valid),
        .dma_ram_rd_resp_ready (resp_ready),
        .req_addr              (req_addr),
        .req_len               (req_len),
        .req_valid             (req_valid),
        .req_ready             (req_ready),
        .m_data                (m_data),
        .m_valid               (m_valid),
        .m_ready               (m_ready),
        .m_last                (m_last),
        .busy                  (busy),
        .done                  (done)
    );

    int unsigned n_checks = 0;
    int unsigned n_err    = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [127:0] ram_word(input int unsigned a);
        return {64'(a), ~64'(a)};
    endfunction

    // Stub RAM: two register stages between command and response
    logic [SEGS-1:0] s1_v, s2_v;
    logic [AW-1:0]   s1_a [SEGS];
    logic [AW-1:0]   s2_a [SEGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v <= '0;
            s2_v <= '0;
        end else begin
            s1_v <= cmd_valid & cmd_ready;
            s2_v <= s1_v;
        end
        for (int n = 0; n < SEGS; n++) begin
            s1_a[n] <= cmd_addr[n*AW +: AW];
            s2_a[n] <= s1_a[n];
        end
    end

    always_comb begin
        resp_valid        = s2_v;
        resp_data[DW-1:0] = ~64'(s2_a[0]);
        resp_data[2*DW-1:DW] = 64'(s2_a[1]);
    end

    // Ready generation
    logic            rand_mode = 1'b0;
    logic            mr_hold = 1'b0;
    logic [SEGS-1:0] cr_low = '0;

    always @(posedge clk) begin
        #1;
        m_ready = mr_hold ? 1'b0 : (rand_mode ? ($urandom % 4 != 0) : 1'b1);
        for (int n = 0; n < SEGS; n++)
            cmd_ready[n] = cr_low[n] ? 1'b0 : (rand_mode ? ($urandom % 3 != 0) : 1'b1);
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    // Reference model and monitor
    logic [127:0] exp_q [$];
    logic [127:0] w;
    int unsigned  cnt [SEGS];
    int unsigned  pops_req = 0;
    int unsigned  mlen = 0;
    logic [AW-1:0] mbase = '0;
    logic         exp_done = 1'b0;
    logic         exp_done_n;
    logic         seen_v = 1'b0;
    int unsigned  acc_cyc = 0, first_v_cyc = 0, done_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            for (int n = 0; n < SEGS; n++) cnt[n] = 0;
            pops_req = 0;
            exp_done = 1'b0;
            seen_v   = 1'b0;
        end else begin
            exp_done_n = 1'b0;
            if (done || exp_done) check("done", done, exp_done);
            if (exp_done) begin
                check("ready_after_done", req_ready, 1);
                check("busy_after_done", busy, 0);
            end
            if (done) done_cnt++;
            if (m_valid && !seen_v) begin
                seen_v = 1'b1;
                first_v_cyc = cyc;
            end
            if (m_valid && exp_q.size() == 0) check("stray_valid", m_valid, 0);
            if (m_valid && m_ready && exp_q.size() != 0) begin
                w = exp_q.pop_front();
                check("data", m_data, w);
                check("last", m_last, exp_q.size() == 0);
                pops_req++;
                if (exp_q.size() == 0) exp_done_n = 1'b1;
            end
            for (int n = 0; n < SEGS; n++) begin
                if (cmd_valid[n] && cmd_ready[n]) begin
                    check("cmd_addr", cmd_addr[n*AW +: AW], AW'(mbase + cnt[n]));
                    cnt[n]++;
                    check("over_issue", cnt[n] <= mlen, 1);
                    check("credit", (cnt[n] - pops_req) <= DEPTH, 1);
                end
            end
            if (req_valid && req_ready) begin
                mbase    = req_addr;
                mlen     = req_len;
                pops_req = 0;
                seen_v   = 1'b0;
                acc_cyc  = cyc;
                for (int n = 0; n < SEGS; n++) cnt[n] = 0;
                for (int unsigned k = 0; k < req_len; k++)
                    exp_q.push_back(ram_word((req_addr + k) % 256));
                if (req_len == 0) exp_done_n = 1'b1;
            end
            exp_done = exp_done_n;
        end
    end

    task automatic do_req(input logic [AW-1:0] a, input logic [LW-1:0] l);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_addr  = a;
        req_len   = l;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("req_timeout", 0, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("done_timeout", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int unsigned d0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_m_last", m_last, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_post_rst", req_ready, 1);

        // basic read, latency and a single done pulse
        d0 = done_cnt;
        do_req(8'h10, 4);
        wait_done();
        check("latency", first_v_cyc - acc_cyc, 4);
        check("done_count_a", done_cnt - d0, 1);

        // consumer stalled: issue must stop at FIFO_DEPTH per segment
        mr_hold = 1'b1;
        do_req(8'h20, 16);
        repeat (20) @(negedge clk);
        check("stall_cnt0", cnt[0], DEPTH);
        check("stall_cnt1", cnt[1], DEPTH);
        check("stall_cmd_valid", cmd_valid, 0);
        mr_hold = 1'b0;
        wait_done();

        // segment 1 held off: segment 0 runs ahead
        cr_low = 2'b10;
        do_req(8'h40, 6);
        repeat (5) @(negedge clk);
        check("seg1_held", cnt[1], 0);
        check("seg0_ahead", cnt[0] > cnt[1], 1);
        cr_low = 2'b00;
        wait_done();

        // address wrap
        do_req(8'hFF, 3);
        wait_done();

        // zero length
        d0 = done_cnt;
        do_req(8'h33, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("zl_cmd_valid", cmd_valid, 0);
            check("zl_m_valid", m_valid, 0);
            check("zl_req_ready", req_ready, 1);
        end
        check("zl_done_count", done_cnt - d0, 1);

        // reset mid-request
        do_req(8'h00, 10);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (pops_req >= 3) break;
        end
        check("mid_pops", pops_req >= 3, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_m_valid", m_valid, 0);
        check("mid_rst_cmd_valid", cmd_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_m_last", m_last, 0);
        check("mid_rst_req_ready", req_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_m_valid", m_valid, 0);
        end
        do_req(8'h00, 2);
        wait_done();

        // randomized requests with random back-pressure
        rand_mode = 1'b1;
        for (int t = 0; t < 10; t++) begin
            do_req(AW'($urandom % 256), LW'($urandom_range(1, 20)));
            wait_done();
        end
        rand_mode = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
